// File: rtl/bip_debug_pkg.sv
// Shared definitions for the BIP debug unit: state encoding, status frame
// layout and the saturating cycle-counter increment.
package bip_debug_pkg;

   // FSM state encoding (plain constants so older tools see fixed values)
   localparam int         NB_STATE    = 3;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CLEAR    = 3'd1;
   localparam logic [2:0] ST_RUN      = 3'd2;
   localparam logic [2:0] ST_TX_LOAD  = 3'd3;
   localparam logic [2:0] ST_TX_WAIT  = 3'd4;

   // Status frame geometry
   localparam int         FRAME_LEN    = 6;
   localparam int         NB_IDX       = 3;
   localparam logic [2:0] LAST_IDX     = 3'(FRAME_LEN - 1);
   localparam int         NB_CYCLE_CNT = 16;
   localparam int         NB_FIELD     = 16;

   // Defaults for the command byte and the halt opcode
   localparam logic [7:0] DEFAULT_START_CMD  = 8'h53;
   localparam logic [4:0] DEFAULT_HLT_OPCODE = 5'b00000;

   // Latched status; declaration order gives the big-endian byte order on the wire
   typedef struct packed {
      logic [NB_FIELD-1:0] pc;
      logic [NB_FIELD-1:0] acc;
      logic [NB_FIELD-1:0] cnt;
   } frame_t;

   // Cycle counter increment that sticks at all-ones instead of wrapping
   function automatic logic [NB_CYCLE_CNT-1:0] sat_inc(input logic [NB_CYCLE_CNT-1:0] value);
      logic [NB_CYCLE_CNT-1:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/bip_debug_frame_mux.sv
// Byte selector for the 6-byte status frame. Index 0 is the most significant
// byte of the PC; out-of-range indices return zero.
module bip_debug_frame_mux
   import bip_debug_pkg::*;
(
   input  frame_t            i_frame,
   input  logic [NB_IDX-1:0] i_idx,
   output logic [7:0]        o_byte
);

   // Pick one byte of the frame, big-endian
   always_comb begin
      o_byte = 8'h00;
      case (i_idx)
         3'd0:    o_byte = i_frame.pc[15:8];
         3'd1:    o_byte = i_frame.pc[7:0];
         3'd2:    o_byte = i_frame.acc[15:8];
         3'd3:    o_byte = i_frame.acc[7:0];
         3'd4:    o_byte = i_frame.cnt[15:8];
         3'd5:    o_byte = i_frame.cnt[7:0];
         default: o_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/bip_debug_unit.sv
// Debug/control wrapper around the BIP core. A start byte from the UART
// resets and launches the processor; when it halts the core is frozen and a
// 6-byte status frame (PC, ACC, cycle count) is streamed to the UART TX.
module bip_debug_unit
   import bip_debug_pkg::*;
#(
   parameter int         NB_DATA            = 16,
   parameter int         NB_OPCODE          = 5,
   parameter int         LOG2_N_INSMEM_ADDR = 11,
   parameter int         NB_BYTE            = 8,
   parameter logic [7:0] START_CMD          = DEFAULT_START_CMD,
   parameter logic [4:0] HLT_OPCODE         = DEFAULT_HLT_OPCODE
)(
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [NB_BYTE-1:0]            i_rx_data,
   input  logic                          i_rx_done,
   output logic [NB_BYTE-1:0]            o_tx_data,
   output logic                          o_tx_start,
   input  logic                          i_tx_done,
   output logic                          o_bip_reset,
   output logic                          o_bip_valid,
   input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
   input  logic [NB_DATA-1:0]            i_acc,
   input  logic [NB_DATA-1:0]            i_instruction
);

   logic [NB_STATE-1:0]     state_r;
   logic [NB_STATE-1:0]     state_next_s;
   logic [NB_IDX-1:0]       idx_r;
   logic [NB_IDX-1:0]       idx_next_s;
   logic [NB_CYCLE_CNT-1:0] cnt_r;
   logic [NB_CYCLE_CNT-1:0] cnt_next_s;
   frame_t                  frame_r;
   frame_t                  frame_next_s;

   logic [NB_FIELD-1:0]     pc_ext_s;
   logic                    start_cmd_s;
   logic                    halt_s;
   logic [7:0]              mux_byte_s;

   logic [NB_BYTE-1:0]      tx_data_r;
   logic                    tx_start_r;
   logic                    bip_reset_r;
   logic                    bip_valid_r;

   // Operand field of the instruction plays no part in halt detection
   logic                    unused_operand_s;
   assign unused_operand_s = ^i_instruction[NB_DATA-NB_OPCODE-1:0];

   assign start_cmd_s = i_rx_done && (i_rx_data == START_CMD);

   // Cycle 0 of a run shows the program memory's post-reset word, so an HLT
   // opcode there is not trusted.
   assign halt_s = (i_instruction[NB_DATA-1 -: NB_OPCODE] == HLT_OPCODE) &&
                   (cnt_r != 16'h0000);

   // Zero-extend the PC into the 16-bit frame field
   always_comb begin
      pc_ext_s = 16'h0000;
      pc_ext_s[LOG2_N_INSMEM_ADDR-1:0] = i_pc;
   end

   // Next-state, counter, frame latch and byte-index logic
   always_comb begin
      state_next_s = state_r;
      idx_next_s   = idx_r;
      cnt_next_s   = cnt_r;
      frame_next_s = frame_r;
      case (state_r)
         ST_IDLE: begin
            if (start_cmd_s) begin
               state_next_s = ST_CLEAR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            cnt_next_s   = 16'h0000;
            state_next_s = ST_RUN;
         end
         ST_RUN: begin
            if (halt_s) begin
               frame_next_s.pc  = pc_ext_s;
               frame_next_s.acc = i_acc;
               frame_next_s.cnt = cnt_r;
               idx_next_s       = 3'd0;
               state_next_s     = ST_TX_LOAD;
            end else begin
               cnt_next_s   = sat_inc(cnt_r);
               state_next_s = ST_RUN;
            end
         end
         ST_TX_LOAD: begin
            state_next_s = ST_TX_WAIT;
         end
         ST_TX_WAIT: begin
            if (i_tx_done) begin
               if (idx_r == LAST_IDX) begin
                  state_next_s = ST_IDLE;
               end else begin
                  idx_next_s   = idx_r + 3'd1;
                  state_next_s = ST_TX_LOAD;
               end
            end else begin
               state_next_s = ST_TX_WAIT;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // The mux looks at the next frame/index so the byte is ready in TX_LOAD
   bip_debug_frame_mux u_frame_mux (
      .i_frame (frame_next_s),
      .i_idx   (idx_next_s),
      .o_byte  (mux_byte_s)
   );

   // State, counter, latches and outputs; outputs are registered from the next state
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r     <= ST_IDLE;
         idx_r       <= 3'd0;
         cnt_r       <= 16'h0000;
         frame_r     <= '0;
         tx_data_r   <= 8'h00;
         tx_start_r  <= 1'b0;
         bip_reset_r <= 1'b0;
         bip_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         idx_r       <= idx_next_s;
         cnt_r       <= cnt_next_s;
         frame_r     <= frame_next_s;
         tx_start_r  <= (state_next_s == ST_TX_LOAD);
         bip_reset_r <= (state_next_s == ST_CLEAR);
         bip_valid_r <= (state_next_s == ST_RUN);
         if (state_next_s == ST_TX_LOAD) begin
            tx_data_r <= mux_byte_s;
         end else begin
            tx_data_r <= tx_data_r;
         end
      end
   end

   assign o_tx_data   = tx_data_r;
   assign o_tx_start  = tx_start_r;
   assign o_bip_reset = bip_reset_r;
   assign o_bip_valid = bip_valid_r;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Directed bench for bip_debug_unit: start/clear/run sequencing, halt
// detection, frame contents and handshake, saturation and mid-frame reset.
module tb_bip_debug_unit;

   logic        i_clock;
   logic        i_reset;
   logic [7:0]  i_rx_data;
   logic        i_rx_done;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        i_tx_done;
   logic        o_bip_reset;
   logic        o_bip_valid;
   logic [10:0] i_pc;
   logic [15:0] i_acc;
   logic [15:0] i_instruction;

   int checks;
   int failures;

   localparam logic [15:0] NONHLT_INSN = 16'h0800;   // opcode 5'b00001
   localparam logic [15:0] HLT_INSN    = 16'h0123;   // opcode 5'b00000, nonzero operand

   bip_debug_unit dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_rx_data     (i_rx_data),
      .i_rx_done     (i_rx_done),
      .o_tx_data     (o_tx_data),
      .o_tx_start    (o_tx_start),
      .i_tx_done     (i_tx_done),
      .o_bip_reset   (o_bip_reset),
      .o_bip_valid   (o_bip_valid),
      .i_pc          (i_pc),
      .i_acc         (i_acc),
      .i_instruction (i_instruction)
   );

   // Free-running clock, 10 time units per period
   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // Strobe the start byte; leaves the DUT in RUN cycle 0
   task automatic start_run(input string tag);
      i_rx_data = 8'h53;
      i_rx_done = 1'b1;
      step();
      i_rx_done = 1'b0;
      chk_bit({tag, "_clear_reset"}, o_bip_reset, 1'b1);
      chk_bit({tag, "_clear_valid"}, o_bip_valid, 1'b0);
      step();
      chk_bit({tag, "_run0_reset"}, o_bip_reset, 1'b0);
      chk_bit({tag, "_run0_valid"}, o_bip_valid, 1'b1);
   endtask

   // Expect one byte in TX_LOAD, hold it for gap+1 cycles, then acknowledge
   task automatic send_byte(input string tag, input logic [7:0] exp, input int gap);
      chk_bit ({tag, "_start"}, o_tx_start, 1'b1);
      chk_byte({tag, "_data"},  o_tx_data,  exp);
      chk_bit ({tag, "_valid"}, o_bip_valid, 1'b0);
      step();
      for (int g = 0; g < gap; g++) begin
         chk_bit({tag, "_wait_start"}, o_tx_start, 1'b0);
         step();
      end
      chk_bit ({tag, "_hold_start"}, o_tx_start, 1'b0);
      chk_byte({tag, "_hold_data"},  o_tx_data,  exp);
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
   endtask

   // Whole frame, then the unit must be back in IDLE
   task automatic send_frame(input string tag, input logic [47:0] frame, input int gap);
      for (int b = 0; b < 6; b++) begin
         send_byte($sformatf("%s_b%0d", tag, b), frame[47-8*b -: 8], gap);
      end
      chk_bit({tag, "_end_start"}, o_tx_start, 1'b0);
      chk_bit({tag, "_end_valid"}, o_bip_valid, 1'b0);
      chk_bit({tag, "_end_reset"}, o_bip_reset, 1'b0);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      i_reset       = 1'b1;
      i_rx_data     = 8'h00;
      i_rx_done     = 1'b0;
      i_tx_done     = 1'b0;
      i_pc          = 11'h000;
      i_acc         = 16'h0000;
      i_instruction = NONHLT_INSN;

      // Reset state
      step();
      step();
      chk_bit ("rst_start", o_tx_start,  1'b0);
      chk_byte("rst_data",  o_tx_data,   8'h00);
      chk_bit ("rst_breset", o_bip_reset, 1'b0);
      chk_bit ("rst_valid", o_bip_valid, 1'b0);
      i_reset = 1'b0;
      step();

      // Non-start byte in IDLE is ignored
      i_rx_data = 8'h41;
      i_rx_done = 1'b1;
      step();
      i_rx_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         chk_byte("ign41_outs", {4'h0, o_bip_reset, o_bip_valid, o_tx_start, 1'b0}, 8'h00);
         chk_byte("ign41_data", o_tx_data, 8'h00);
         step();
      end

      // Run: HLT at RUN cycle 9 with pc=009, acc=1234
      i_instruction = NONHLT_INSN;
      start_run("r1");
      for (int c = 1; c <= 9; c++) begin
         step();
         chk_bit("r1_run_valid", o_bip_valid, 1'b1);
         chk_bit("r1_run_start", o_tx_start, 1'b0);
         if (c == 9) begin
            i_instruction = HLT_INSN;
            i_pc          = 11'h009;
            i_acc         = 16'h1234;
         end else begin
            i_pc  = 11'(c);
            i_acc = 16'hDEAD;
         end
      end
      step();
      send_frame("r1", 48'h0009_1234_0009, 3);

      // HLT visible at RUN cycle 0 is masked; start byte during RUN ignored
      i_instruction = HLT_INSN;
      i_pc          = 11'h555;
      i_acc         = 16'hAAAA;
      start_run("r2");
      step();
      chk_bit("r2_c1_valid", o_bip_valid, 1'b1);
      chk_bit("r2_c1_start", o_tx_start, 1'b0);
      i_instruction = NONHLT_INSN;
      i_rx_data     = 8'h53;
      i_rx_done     = 1'b1;
      step();
      i_rx_done = 1'b0;
      chk_bit("r2_c2_breset", o_bip_reset, 1'b0);
      chk_bit("r2_c2_valid", o_bip_valid, 1'b1);
      step();
      step();
      i_instruction = HLT_INSN;
      i_pc          = 11'h7FF;
      i_acc         = 16'hBEEF;
      step();
      send_frame("r2", 48'h07FF_BEEF_0004, 0);

      // Counter saturation: HLT at RUN cycle 70000
      i_instruction = NONHLT_INSN;
      start_run("r3");
      for (int c = 1; c <= 70000; c++) begin
         step();
         if (c == 70000) begin
            chk_bit("r3_run_valid", o_bip_valid, 1'b1);
            i_instruction = HLT_INSN;
            i_pc          = 11'h400;
            i_acc         = 16'hFFFF;
         end
      end
      step();
      send_frame("r3", 48'h0400_FFFF_FFFF, 1);

      // Reset in TX_WAIT of byte 2 abandons the frame
      i_instruction = NONHLT_INSN;
      start_run("r4");
      step();
      step();
      step();
      i_instruction = HLT_INSN;
      i_pc          = 11'h003;
      i_acc         = 16'h00FF;
      step();
      send_byte("r4_b0", 8'h00, 0);
      send_byte("r4_b1", 8'h03, 0);
      chk_bit ("r4_b2_start", o_tx_start, 1'b1);
      chk_byte("r4_b2_data",  o_tx_data,  8'h00);
      step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk_bit ("r4_rst_start",  o_tx_start,  1'b0);
      chk_byte("r4_rst_data",   o_tx_data,   8'h00);
      chk_bit ("r4_rst_breset", o_bip_reset, 1'b0);
      chk_bit ("r4_rst_valid",  o_bip_valid, 1'b0);
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk_bit("r4_idle_start", o_tx_start, 1'b0);
         chk_bit("r4_idle_valid", o_bip_valid, 1'b0);
         step();
      end

      // Clean restart after reset: HLT at RUN cycle 1
      i_instruction = NONHLT_INSN;
      start_run("r5");
      step();
      i_instruction = HLT_INSN;
      i_pc          = 11'h001;
      i_acc         = 16'h5A5A;
      step();
      send_frame("r5", 48'h0001_5A5A_0001, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
